// File: rtl/seg_result_pager.sv
// 7-segment pager for a wide result word: hex paging (4 bits/digit) or decimal byte paging
// through an iterative 8-step double-dabble that runs while the display holds its last value.

module seg_glyph (
  input  logic       blank,
  input  logic [3:0] val,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      case (val)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        default: seg = 7'b0001110;
      endcase
    end
  end
endmodule

module seg_result_pager #(
  parameter int DATA_W       = 128,
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 8,
  localparam int PG_W        = $clog2(DATA_W/8)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  input  logic                    dec_mode,
  input  logic                    auto_scroll,
  input  logic                    next_page,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [PG_W-1:0]         page,
  output logic                    busy
);
  localparam int NP_HEX   = DATA_W/(4*NUM_DIGITS);
  localparam int NP_DEC   = DATA_W/8;
  localparam int DW_W     = $clog2(DWELL_CYCLES);
  localparam int DIG_BITS = 4*NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, SHOW_HEX, CONVERT, SHOW_DEC} state_t;

  state_t                          state;
  logic [DATA_W-1:0]               data_r;
  logic [DW_W-1:0]                 dwell;
  logic [19:0]                     conv;   // {hundreds, tens, ones, binary}
  logic [2:0]                      cnt;
  logic [NUM_DIGITS-1:0][6:0]      seg_next;
  logic [NUM_DIGITS-1:0][3:0]      dig_val;
  logic [NUM_DIGITS-1:0]           dig_blank;
  logic [DIG_BITS-1:0]             page_word;
  logic [PG_W-1:0]                 last_pg, page_nxt;
  logic                            show, capture, mode_chg, advance;

  function automatic logic [7:0] byte_of(input logic [DATA_W-1:0] d, input logic [PG_W-1:0] p);
    return 8'(d >> (8*int'(p)));
  endfunction

  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    for (int k = 0; k < 3; k++)
      if (t[8+4*k +: 4] >= 4'd5) t[8+4*k +: 4] = t[8+4*k +: 4] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  assign busy     = (state == CONVERT);
  assign in_ready = ~busy;
  assign show     = (state == SHOW_HEX) || (state == SHOW_DEC);
  assign capture  = in_valid && in_ready;
  assign mode_chg = ((state == SHOW_HEX) && dec_mode) ||
                    (((state == CONVERT) || (state == SHOW_DEC)) && !dec_mode);
  assign last_pg  = (state == SHOW_DEC) ? PG_W'(NP_DEC-1) : PG_W'(NP_HEX-1);
  assign page_nxt = (page == last_pg) ? '0 : page + 1'b1;
  assign advance  = show && (next_page || (auto_scroll && dwell == DW_W'(DWELL_CYCLES-1)));
  assign page_word = DIG_BITS'(data_r >> (DIG_BITS*int'(page)));

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    if (i < 3) begin : g_bcd
      assign dig_val[i]   = (state == SHOW_DEC) ? conv[8+4*i +: 4] : page_word[4*i +: 4];
      assign dig_blank[i] = 1'b0;
    end else begin : g_hex
      assign dig_val[i]   = page_word[4*i +: 4];
      assign dig_blank[i] = (state == SHOW_DEC);
    end
    seg_glyph u_glyph (.blank(dig_blank[i]), .val(dig_val[i]), .seg(seg_next[i]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      page   <= '0;
      dwell  <= '0;
      data_r <= '0;
      conv   <= '0;
      cnt    <= '0;
      hex    <= '1;
    end else begin
      // Display follows the state as it stood before this edge; CONVERT freezes it.
      case (state)
        IDLE:    hex <= '1;
        CONVERT: hex <= hex;
        default: hex <= seg_next;
      endcase
      if (capture) begin
        data_r <= in_data;
        page   <= '0;
        dwell  <= '0;
        conv   <= {12'b0, in_data[7:0]};
        cnt    <= '0;
        state  <= dec_mode ? CONVERT : SHOW_HEX;
      end else if (mode_chg) begin
        page  <= '0;
        dwell <= '0;
        conv  <= {12'b0, byte_of(data_r, '0)};
        cnt   <= '0;
        state <= dec_mode ? CONVERT : SHOW_HEX;
      end else if (state == CONVERT) begin
        conv <= dd_step(conv);
        cnt  <= cnt + 3'd1;
        if (cnt == 3'd7) state <= SHOW_DEC;
      end else if (advance) begin
        page  <= page_nxt;
        dwell <= '0;
        if (state == SHOW_DEC) begin
          state <= CONVERT;
          conv  <= {12'b0, byte_of(data_r, page_nxt)};
          cnt   <= '0;
        end
      end else if (show && auto_scroll) begin
        dwell <= dwell + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_result_pager.sv
// Scoreboard bench: a behavioural pager model pushes the expected display per cycle,
// a negedge monitor pops and compares against the DUT outputs.

module tb_seg_result_pager;
  localparam int DATA_W = 128;
  localparam int ND     = 4;
  localparam int DW     = 8;

  localparam logic [6:0] GLYPH [0:16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110, 7'b1111111};

  logic              clk = 1'b0;
  logic              reset, in_valid, in_ready, dec_mode, auto_scroll, next_page, busy;
  logic [DATA_W-1:0] in_data;
  logic [7*ND-1:0]   hex;
  logic [3:0]        page;

  always #5 clk = ~clk;

  seg_result_pager #(.DATA_W(DATA_W), .NUM_DIGITS(ND), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dec_mode(dec_mode), .auto_scroll(auto_scroll), .next_page(next_page),
    .hex(hex), .page(page), .busy(busy));

  typedef struct {
    logic [7*ND-1:0] hex;
    logic [3:0]      page;
    logic            busy;
    logic            rdy;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;

  // model: idle flag, display mode, remaining conversion cycles, page, dwell, data, shown glyphs
  bit              m_idle = 1'b1, m_dec = 1'b0;
  int              m_left = 0, m_page = 0, m_dwell = 0;
  logic [DATA_W-1:0] m_data = '0;
  logic [7*ND-1:0] m_hex = '1;
  bit              cur_dm = 1'b0, cur_as = 1'b0;

  function automatic logic [7*ND-1:0] render(input logic [DATA_W-1:0] d, input bit dec, input int pg);
    logic [7*ND-1:0]   h;
    logic [DATA_W-1:0] s;
    int                b, dg;
    h = '1;
    if (!dec) begin
      s = d >> (pg*4*ND);
      for (int i = 0; i < ND; i++) h[7*i +: 7] = GLYPH[s[4*i +: 4]];
    end else begin
      b = int'(8'(d >> (pg*8)));
      for (int i = 0; i < ND; i++) begin
        dg = (i == 0) ? b % 10 : (i == 1) ? (b / 10) % 10 : (i == 2) ? b / 100 : 16;
        h[7*i +: 7] = GLYPH[dg];
      end
    end
    return h;
  endfunction

  task automatic model_step(input bit r, input bit iv, input logic [DATA_W-1:0] d,
                            input bit dm, input bit as, input bit np);
    bit   rdy, adv;
    int   npg;
    exp_t e;
    if (r) begin
      m_idle = 1; m_dec = 0; m_left = 0; m_page = 0; m_dwell = 0; m_data = '0; m_hex = '1;
    end else begin
      rdy = (m_left == 0);
      if (m_idle) m_hex = '1;
      else if (m_left == 0) m_hex = render(m_data, m_dec, m_page);
      if (iv && rdy) begin
        m_data = d; m_page = 0; m_dwell = 0; m_idle = 0; m_dec = dm; m_left = dm ? 8 : 0;
      end else if (!m_idle && dm != m_dec) begin
        m_page = 0; m_dwell = 0; m_dec = dm; m_left = dm ? 8 : 0;
      end else if (!m_idle && m_left > 0) begin
        m_left--;
      end else if (!m_idle) begin
        npg = m_dec ? DATA_W/8 : DATA_W/(4*ND);
        adv = np || (as && m_dwell == DW-1);
        if (adv) begin
          m_page = (m_page + 1) % npg; m_dwell = 0;
          if (m_dec) m_left = 8;
        end else if (as) m_dwell++;
      end
    end
    e.hex = m_hex; e.page = 4'(m_page); e.busy = (m_left > 0); e.rdy = (m_left == 0);
    q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit iv, input logic [DATA_W-1:0] d, input bit np);
    reset = r; in_valid = iv; in_data = d; dec_mode = cur_dm; auto_scroll = cur_as; next_page = np;
    @(posedge clk);
    model_step(r, iv, d, cur_dm, cur_as, np);
    #1;
  endtask

  task automatic step(input bit iv, input logic [DATA_W-1:0] d, input bit np);
    cyc(1'b0, iv, d, np);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", n, $time, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hex", 32'(hex), 32'(e.hex));
        chk("page", 32'(page), 32'(e.page));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("in_ready", 32'(in_ready), 32'(e.rdy));
      end
    end
  end

  localparam logic [DATA_W-1:0] D0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [DATA_W-1:0] D1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DATA_W-1:0] D2 = 128'hfedcba98765432100123456789abcdef;

  initial begin : stim
    int guard;
    reset = 1; in_valid = 0; in_data = '0; dec_mode = 0; auto_scroll = 0; next_page = 0;
    repeat (2) cyc(1'b1, 1'b0, '0, 1'b0);
    // hex capture and manual paging with wrap
    step(1, D0, 0); step(0, '0, 0); step(0, '0, 0);
    repeat (8) begin step(0, '0, 1); step(0, '0, 0); end
    // decimal capture, paging through all bytes and wrap
    cur_dm = 1;
    step(1, D0, 0);
    repeat (10) step(0, '0, 0);
    repeat (16) begin step(0, '0, 1); repeat (10) step(0, '0, 0); end
    // auto-scroll in hex, early next_page, capture beating next_page
    cur_dm = 0;
    step(1, D1, 0);
    cur_as = 1;
    repeat (20) step(0, '0, 0);
    guard = 0;
    while (m_dwell != 5 && guard < 20) begin step(0, '0, 0); guard++; end
    step(0, '0, 1);
    repeat (3) step(0, '0, 0);
    step(1, D2, 1);
    repeat (12) step(0, '0, 0);
    cur_as = 0;
    // reset on the 4th conversion cycle
    cur_dm = 1;
    step(1, D0, 0);
    repeat (3) step(0, '0, 0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    repeat (3) step(0, '0, 0);
    // mode drop mid-conversion; capture attempt during conversion ignored
    step(1, D1, 0);
    repeat (2) step(0, '0, 0);
    step(1, D2, 0);
    cur_dm = 0;
    repeat (4) step(0, '0, 0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) cur_dm = !cur_dm;
      if ($urandom_range(0, 59) == 0) cur_as = !cur_as;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
          {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 7) == 0);
    end
    @(negedge clk); @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
